// File: rtl/window_mac.sv
// 3x3 window multiply-accumulate stage: one MAC per cycle, one signed result per window.
// Optional build macro WINDOW_MAC_RELU_EN clamps negative results to zero before saturation.
module window_mac #(
  parameter int DATA_W = 8,
  parameter int WGT_W  = 8,
  parameter int TAPS   = 9,
  parameter int OUT_W  = 21
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     w_we,
  input  logic [3:0]               w_addr,
  input  logic [WGT_W-1:0]         w_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [TAPS*DATA_W-1:0]   in_window,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_data,
  output logic                     busy
);

  // state | meaning
  // IDLE  | ready for a window, kernel writes accepted
  // MAC   | one tap per cycle, taps 0..8
  // DONE  | result presented, waiting for out_ready

  localparam int ACC_W  = DATA_W + WGT_W + 1 + 4;
  localparam int PROD_W = DATA_W + WGT_W + 1;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                    state, state_nxt;
  logic [CNT_W-1:0]          cnt;
  logic [DATA_W-1:0]         pix [TAPS];
  logic signed [WGT_W-1:0]   wgt [TAPS];
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   acc_nxt;
  logic signed [ACC_W-1:0]   res;
  logic signed [PROD_W-1:0]  prod;
  logic [OUT_W-1:0]          res_sat;
  logic                      take;
  logic                      last_tap;
  logic                      w_hit;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign take     = in_valid & in_ready;
  assign last_tap = (cnt == CNT_W'(TAPS - 1));
  assign w_hit    = w_we && (state == IDLE) && (w_addr <= CNT_W'(TAPS - 1));

  // Pixels are unsigned, so a zero MSB is prepended before the signed multiply.
  always_comb begin
    prod    = PROD_W'($signed({1'b0, pix[cnt]})) * PROD_W'(wgt[cnt]);
    acc_nxt = acc + ACC_W'(prod);
  end

`ifdef WINDOW_MAC_RELU_EN
  assign res = acc_nxt[ACC_W-1] ? '0 : acc_nxt;
`else
  assign res = acc_nxt;
`endif

  generate
    if (OUT_W < ACC_W) begin : g_sat
      localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
      localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
      always_comb begin
        if (res > SAT_MAX)      res_sat = SAT_MAX[OUT_W-1:0];
        else if (res < SAT_MIN) res_sat = SAT_MIN[OUT_W-1:0];
        else                    res_sat = res[OUT_W-1:0];
      end
    end else begin : g_pass
      assign res_sat = OUT_W'(res);
    end
  endgenerate

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = MAC;
      MAC:     if (last_tap) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A write in the handshake cycle lands before the first MAC cycle reads the kernel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) wgt[k] <= '0;
    end else if (w_hit) begin
      wgt[w_addr] <= w_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) pix[k] <= '0;
      cnt       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            for (int k = 0; k < TAPS; k++) pix[k] <= in_window[DATA_W*k +: DATA_W];
            acc <= '0;
            cnt <= '0;
          end
        end
        MAC: begin
          acc <= acc_nxt;
          cnt <= cnt + 1'b1;
          if (last_tap) begin
            out_valid <= 1'b1;
            out_data  <= res_sat;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_window_mac.sv
// Directed and randomized bench for window_mac; a full-width and a 16-bit saturating instance
// share one stimulus and are checked against an arithmetic reference of the convolution.
module tb_window_mac;

  logic        clk = 1'b0;
  logic        rst;
  logic        w_we;
  logic [3:0]  w_addr;
  logic [7:0]  w_data;
  logic        in_valid;
  logic [71:0] in_window;
  logic        out_ready;

  logic        in_ready, out_valid, busy;
  logic [20:0] out_data;
  logic        in_ready16, out_valid16, busy16;
  logic [15:0] out_data16;

  int n_cmp = 0;
  int n_bad = 0;
  int wm[9];
  int pm[9];

  always #5 clk = ~clk;

  window_mac #(.DATA_W(8), .WGT_W(8), .TAPS(9), .OUT_W(21)) dut (
    .clk(clk), .rst(rst), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_window(in_window),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  window_mac #(.DATA_W(8), .WGT_W(8), .TAPS(9), .OUT_W(16)) dut16 (
    .clk(clk), .rst(rst), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .in_valid(in_valid), .in_ready(in_ready16), .in_window(in_window),
    .out_valid(out_valid16), .out_ready(out_ready), .out_data(out_data16), .busy(busy16)
  );

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Dot product of the current window and kernel, then optional clamp and saturation.
  function automatic longint model(input int out_w);
    longint s = 0;
    longint lim;
    for (int k = 0; k < 9; k++) s += longint'(pm[k]) * longint'(wm[k]);
`ifdef WINDOW_MAC_RELU_EN
    if (s < 0) s = 0;
`endif
    lim = longint'(1) <<< (out_w - 1);
    if (out_w < 21) begin
      if (s > lim - 1) s = lim - 1;
      if (s < -lim) s = -lim;
    end
    return s;
  endfunction

  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    w_we = 1'b1; w_addr = a; w_data = d;
    @(posedge clk);
    #1 w_we = 1'b0;
    if (a <= 4'd8) wm[a] = int'($signed(d));
  endtask

  task automatic run_window(input int hold, input bit wr_same, input logic [3:0] wa, input logic [7:0] wd);
    logic [71:0] win;
    logic [20:0] held21;
    logic [15:0] held16;
    longint e21, e16;
    int lat;
    for (int k = 0; k < 9; k++) win[8*k +: 8] = 8'(pm[k]);
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    check("in_ready16_idle", in_ready16, 1);
    in_valid = 1'b1; in_window = win;
    if (wr_same) begin w_we = 1'b1; w_addr = wa; w_data = wd; end
    @(posedge clk);
    if (wr_same && wa <= 4'd8) wm[wa] = int'($signed(wd));
    e21 = model(21);
    e16 = model(16);
    lat = 21;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      in_valid = 1'b0;
      w_we = (n == 3); w_addr = 4'd0; w_data = 8'd5;
      in_window = {8'($urandom), 32'($urandom), 32'($urandom)};
      if (out_valid) begin lat = n; break; end
      check("mac_busy", busy, 1);
      check("mac_in_ready", in_ready, 0);
    end
    w_we = 1'b0;
    check("latency", lat, 10);
    check("valid16", out_valid16, 1);
    check("result21", $signed(out_data), e21);
    check("result16", $signed(out_data16), e16);
    held21 = out_data;
    held16 = out_data16;
    for (int h = 0; h < hold; h++) begin
      w_we = 1'b1; w_addr = 4'($urandom_range(0, 15)); w_data = 8'($urandom);
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_data21", $signed(out_data), $signed(held21));
      check("hold_data16", $signed(out_data16), $signed(held16));
    end
    w_we = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("accept_valid", out_valid, 0);
    check("accept_in_ready", in_ready, 1);
    check("accept_busy", busy, 0);
  endtask

  initial begin
    rst = 1'b1; w_we = 1'b0; w_addr = '0; w_data = '0;
    in_valid = 1'b0; in_window = '0; out_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin wm[k] = 0; pm[k] = 0; end
    #12;
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_data", $signed(out_data), 0);
    @(negedge clk);
    rst = 1'b0;

    // all-ones kernel, ramp window
    for (int k = 0; k < 9; k++) do_write(4'(k), 8'd1);
    for (int k = 0; k < 9; k++) pm[k] = k + 1;
    run_window(0, 1'b0, 4'd0, 8'd0);

    // most negative result and 16-bit saturation
    for (int k = 0; k < 9; k++) do_write(4'(k), 8'h80);
    for (int k = 0; k < 9; k++) pm[k] = 255;
    run_window(1, 1'b0, 4'd0, 8'd0);

    // most positive result
    for (int k = 0; k < 9; k++) do_write(4'(k), 8'd127);
    run_window(0, 1'b0, 4'd0, 8'd0);

    // held result, then write in IDLE vs dropped writes during MAC/DONE
    for (int k = 0; k < 9; k++) do_write(4'(k), 8'd1);
    for (int k = 0; k < 9; k++) pm[k] = k + 1;
    run_window(5, 1'b0, 4'd0, 8'd0);
    do_write(4'd0, 8'd5);
    run_window(2, 1'b0, 4'd0, 8'd0);

    // out-of-range address ignored; write in the handshake cycle applied
    do_write(4'd12, 8'd77);
    run_window(0, 1'b1, 4'd8, 8'hFD);

    for (int it = 0; it < 16; it++) begin
      int nwr;
      nwr = $urandom_range(0, 3);
      for (int j = 0; j < nwr; j++) do_write(4'($urandom_range(0, 15)), 8'($urandom));
      for (int k = 0; k < 9; k++) pm[k] = $urandom_range(0, 255);
      run_window($urandom_range(0, 3), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom));
    end

    // reset in the middle of MAC
    for (int k = 0; k < 9; k++) pm[k] = $urandom_range(1, 255);
    @(negedge clk);
    in_valid = 1'b1;
    for (int k = 0; k < 9; k++) in_window[8*k +: 8] = 8'(pm[k]);
    @(posedge clk);
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    #1 rst = 1'b1;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_data", $signed(out_data), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 9; k++) wm[k] = 0;
    run_window(0, 1'b0, 4'd0, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
